mant_norm_pipe: RTL and testbench

Two-stage pipelined post-addition normalizer for the multi-precision posit adder. It sits directly downstream of the mantissa alignment/add stage and consumes its 68-bit packed sum `mant_pl` together with the per-lane result scale and the precision mode. For each active lane it performs a leading-zero count, shifts the lane left so its leading one lands on the lane MSB, and adjusts the lane scale. Results are passed to the posit encode stage under a valid/ready handshake.

---
 rtl/mant_norm_pipe.sv | 160 ++++++++++++++++
 tb/tb_mant_norm_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mant_norm_pipe.sv
// Two-stage post-addition normalizer for the multi-precision posit adder.
// S1 registers the raw bundle plus per-lane leading-zero counts; S2 shifts, rescales and drives the outputs.
module mant_norm_pipe #(
  parameter int unsigned LANE_SCALE_W = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [67:0]                 mant_pl,
  input  logic [4*LANE_SCALE_W-1:0]   scale_in,
  input  logic [1:0]                  in_pre,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [67:0]                 mant_norm,
  output logic [4*LANE_SCALE_W-1:0]   scale_out,
  output logic [3:0]                  lane_zero,
  output logic [1:0]                  pre_out
);

  localparam int unsigned MANT_W  = 68;
  localparam int unsigned SCALE_W = 4 * LANE_SCALE_W;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned LANES   = 4;

  // Lane geometry per precision mode; the reserved mode has no active lanes.
  function automatic logic [CNT_W-1:0] lane_width(input logic [1:0] pre);
    case (pre)
      2'b00:   return CNT_W'(17);
      2'b01:   return CNT_W'(34);
      2'b10:   return CNT_W'(57);
      default: return '0;
    endcase
  endfunction

  function automatic logic [2:0] lane_count(input logic [1:0] pre);
    case (pre)
      2'b00:   return 3'd4;
      2'b01:   return 3'd2;
      2'b10:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [MANT_W-1:0] lane_mask(input logic [CNT_W-1:0] w);
    return (MANT_W'(1) << w) - MANT_W'(1);
  endfunction

  function automatic logic [MANT_W-1:0] lane_get(input logic [MANT_W-1:0] v,
                                                 input logic [1:0] idx,
                                                 input logic [CNT_W-1:0] w);
    return (v >> (CNT_W'(idx) * w)) & lane_mask(w);
  endfunction

  // Leading zeros within the low w bits; an all-zero lane yields w.
  function automatic logic [CNT_W-1:0] lzc(input logic [MANT_W-1:0] v,
                                           input logic [CNT_W-1:0] w);
    logic [CNT_W-1:0] n;
    logic             found;
    n     = w;
    found = 1'b0;
    for (int i = int'(MANT_W) - 1; i >= 0; i--) begin
      if (!found && (CNT_W'(i) < w) && v[i]) begin
        n     = w - CNT_W'(1) - CNT_W'(i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic                        s1_valid;
  logic [MANT_W-1:0]           s1_mant;
  logic [SCALE_W-1:0]          s1_scale;
  logic [1:0]                  s1_pre;
  logic [LANES-1:0][CNT_W-1:0] s1_lzc;
  logic [LANES-1:0][CNT_W-1:0] lzc_c;
  logic                        s1_adv;
  logic                        s2_adv;

  logic [MANT_W-1:0]           mant_d;
  logic [SCALE_W-1:0]          scale_d;
  logic [LANES-1:0]            zero_d;
  logic [CNT_W-1:0]            w_s2;
  logic [MANT_W-1:0]           mask_s2;
  logic [MANT_W-1:0]           lane_s2;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    lzc_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (3'(i) < lane_count(in_pre))
        lzc_c[i] = lzc(lane_get(mant_pl, 2'(i), lane_width(in_pre)), lane_width(in_pre));
    end
  end

  // Shift each active lane so its leading one lands on the lane MSB and rescale.
  always_comb begin
    mant_d  = '0;
    scale_d = '0;
    zero_d  = (s1_pre == 2'b11) ? '1 : '0;
    w_s2    = lane_width(s1_pre);
    mask_s2 = lane_mask(w_s2);
    lane_s2 = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_s2 = lane_get(s1_mant, 2'(i), w_s2);
      if (3'(i) < lane_count(s1_pre)) begin
        if (s1_lzc[i] == w_s2) begin
          zero_d[i] = 1'b1;
        end else begin
          mant_d = mant_d | (((lane_s2 << s1_lzc[i]) & mask_s2) << (CNT_W'(i) * w_s2));
          scale_d[i*LANE_SCALE_W +: LANE_SCALE_W] =
            s1_scale[i*LANE_SCALE_W +: LANE_SCALE_W] + LANE_SCALE_W'(1)
            - LANE_SCALE_W'(s1_lzc[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mant   <= '0;
      s1_scale  <= '0;
      s1_pre    <= '0;
      s1_lzc    <= '0;
      out_valid <= 1'b0;
      mant_norm <= '0;
      scale_out <= '0;
      lane_zero <= '0;
      pre_out   <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mant  <= mant_pl;
          s1_scale <= scale_in;
          s1_pre   <= in_pre;
          s1_lzc   <= lzc_c;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          mant_norm <= mant_d;
          scale_out <= scale_d;
          lane_zero <= zero_d;
          pre_out   <= s1_pre;
        end
      end
    end
  end

endmodule

// File: tb/tb_mant_norm_pipe.sv
// Self-checking bench for mant_norm_pipe: directed vectors, random streaming against
// an iterative-normalization reference model, back-pressure, flush and async reset.
module tb_mant_norm_pipe;

  localparam int unsigned LSW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [67:0]   mant_pl;
  logic [39:0]   scale_in;
  logic [1:0]    in_pre;
  logic          out_valid;
  logic          out_ready;
  logic [67:0]   mant_norm;
  logic [39:0]   scale_out;
  logic [3:0]    lane_zero;
  logic [1:0]    pre_out;

  typedef struct packed {
    logic [67:0] m;
    logic [39:0] s;
    logic [3:0]  z;
    logic [1:0]  p;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  mant_norm_pipe #(.LANE_SCALE_W(LSW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mant_pl(mant_pl), .scale_in(scale_in), .in_pre(in_pre),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_norm(mant_norm), .scale_out(scale_out),
    .lane_zero(lane_zero), .pre_out(pre_out)
  );

  always #5 clk = ~clk;

  // Reference: double the lane value until its top bit is set, decrementing the scale each time.
  function automatic exp_t model(input logic [67:0] m, input logic [39:0] s, input logic [1:0] p);
    exp_t e;
    int   w, n;
    e   = '0;
    e.p = p;
    case (p)
      2'b00:   begin w = 17; n = 4; end
      2'b01:   begin w = 34; n = 2; end
      2'b10:   begin w = 57; n = 1; end
      default: begin w = 0;  n = 0; e.z = 4'b1111; end
    endcase
    for (int i = 0; i < n; i++) begin
      logic [67:0] v;
      logic [9:0]  sc;
      v  = (m >> (i * w)) & ((68'(1) << w) - 68'(1));
      sc = s[i*10 +: 10];
      if (v == 68'd0) begin
        e.z[i] = 1'b1;
      end else begin
        sc = sc + 10'd1;
        while (v[w-1] == 1'b0) begin
          v  = v << 1;
          sc = sc - 10'd1;
        end
        e.m = e.m | (v << (i * w));
        e.s[i*10 +: 10] = sc;
      end
    end
    return e;
  endfunction

  task automatic gen_bundle(output logic [67:0] m, output logic [39:0] s, output logic [1:0] p);
    int w, n;
    logic [67:0] v, mask;
    p = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    s = {8'($urandom), $urandom};
    m = 68'({$urandom, $urandom, $urandom});
    case (p)
      2'b00:   begin w = 17; n = 4; end
      2'b01:   begin w = 34; n = 2; end
      2'b10:   begin w = 57; n = 1; end
      default: begin w = 0;  n = 0; end
    endcase
    if (n > 0) begin
      mask = (68'(1) << w) - 68'(1);
      m = (p == 2'b10) ? (m & ~mask) : 68'd0;
      for (int i = 0; i < n; i++) begin
        v = 68'({$urandom, $urandom}) & mask;
        case ($urandom_range(0, 5))
          0:       v = 68'd0;
          1:       v = v | (68'(1) << (w - 1));
          default: v = v >> $urandom_range(0, w);
        endcase
        m = m | (v << (i * w));
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid act=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready act=%b exp=1", in_ready); end
    checks++;
    if ({mant_norm, scale_out, lane_zero, pre_out} !== 114'd0) begin
      failures++;
      $display("FAIL reset_outputs act=%h exp=0", {mant_norm, scale_out, lane_zero, pre_out});
    end
  endtask

  task automatic test_directed();
    logic [67:0] dm [4];
    logic [39:0] ds [4];
    logic [1:0]  dp [4];
    logic [67:0] em [4];
    logic [39:0] es [4];
    logic [3:0]  ez [4];
    exp_t act, exp;
    dm[0] = 68'h1;             ds[0] = 40'd5;                 dp[0] = 2'b00;
    em[0] = 68'h10000;         es[0] = 40'h3F6;               ez[0] = 4'b1110;
    dm[1] = 68'h18000 << 51;   ds[1] = 40'h3FD << 30;         dp[1] = 2'b00;
    em[1] = 68'h18000 << 51;   es[1] = 40'h3FE << 30;         ez[1] = 4'b0111;
    dm[2] = 68'h1 << 55;       ds[2] = 40'd100;               dp[2] = 2'b10;
    em[2] = 68'h1 << 56;       es[2] = 40'd100;               ez[2] = 4'b0000;
    dm[3] = 68'h1;             ds[3] = (40'd7 << 10) | 40'd7; dp[3] = 2'b01;
    em[3] = 68'h1 << 33;       es[3] = 40'h3E7;               ez[3] = 4'b0010;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      mant_pl = dm[v]; scale_in = ds[v]; in_pre = dp[v];
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready act=%b exp=1", v, in_ready); end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early_valid act=%b exp=0", v, out_valid); end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL dir%0d_latency act=%b exp=1", v, out_valid); end
      act = {mant_norm, scale_out, lane_zero, pre_out};
      exp = {em[v], es[v], ez[v], dp[v]};
      checks++;
      if (act !== exp) begin failures++; $display("FAIL dir%0d_data act=%h exp=%h", v, act, exp); end
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [67:0] m;
    logic [39:0] s;
    logic [1:0]  p;
    exp_t act, held;
    bit   stalled, exp_ready;
    q.delete();
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 430; c++) begin
      @(negedge clk);
      gen_bundle(m, s, p);
      mant_pl = m; scale_in = s; in_pre = p;
      in_valid  = (c < 400) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 400) || ($urandom_range(0, 2) != 0);
      #1;
      exp_ready = !(q.size() >= 2 && !out_ready);
      checks++;
      if (in_ready !== exp_ready) begin failures++; $display("FAIL b2b_in_ready cyc=%0d act=%b exp=%b", c, in_ready, exp_ready); end
      act = {mant_norm, scale_out, lane_zero, pre_out};
      if (stalled) begin
        checks++;
        if (act !== held || out_valid !== 1'b1) begin
          failures++; $display("FAIL b2b_hold cyc=%0d act=%h exp=%h", c, act, held);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_spurious cyc=%0d act=%h exp=none", c, act);
        end else if (act !== q[0]) begin
          failures++; $display("FAIL b2b_data cyc=%0d act=%h exp=%h", c, act, q[0]);
        end
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(mant_pl, scale_in, in_pre));
      stalled = out_valid && !out_ready;
      held    = act;
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL b2b_drain act=%0d exp=0 pending", q.size()); end
  endtask

  task automatic test_back_pressure();
    logic [67:0] m;
    logic [39:0] s;
    logic [1:0]  p;
    exp_t act, held;
    bit   stalled, exp_ready;
    int   sent, emitted;
    q.delete();
    stalled = 1'b0; held = '0; sent = 0; emitted = 0;
    gen_bundle(m, s, p);
    if (p == 2'b11) p = 2'b00;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sent == 6) p = 2'b11;
      mant_pl = m; scale_in = s; in_pre = p;
      in_valid  = (sent < 7);
      out_ready = (c % 3 == 0);
      #1;
      exp_ready = !(q.size() >= 2 && !out_ready);
      checks++;
      if (in_ready !== exp_ready) begin failures++; $display("FAIL bp_in_ready cyc=%0d act=%b exp=%b", c, in_ready, exp_ready); end
      act = {mant_norm, scale_out, lane_zero, pre_out};
      if (stalled) begin
        checks++;
        if (act !== held || out_valid !== 1'b1) begin
          failures++; $display("FAIL bp_hold cyc=%0d act=%h exp=%h", c, act, held);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL bp_spurious cyc=%0d act=%h exp=none", c, act);
        end else if (act !== q[0]) begin
          failures++; $display("FAIL bp_data cyc=%0d act=%h exp=%h", c, act, q[0]);
        end
        if (out_ready && q.size() > 0) begin void'(q.pop_front()); emitted++; end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(mant_pl, scale_in, in_pre));
        sent++;
        gen_bundle(m, s, p);
        if (p == 2'b11) p = 2'b01;
      end
      stalled = out_valid && !out_ready;
      held    = act;
    end
    checks++;
    if (emitted != 7 || q.size() != 0) begin
      failures++; $display("FAIL bp_count act=%0d exp=7 pending=%0d", emitted, q.size());
    end
  endtask

  task automatic test_flush_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    mant_pl = 68'h1; scale_in = 40'd5; in_pre = 2'b00;
    @(posedge clk);
    @(negedge clk);
    mant_pl = 68'h1 << 55; scale_in = 40'd100; in_pre = 2'b10;
    @(posedge clk);
    @(negedge clk);
    mant_pl = 68'h3; in_pre = 2'b01;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL flush_full act=%b%b exp=01", in_ready, out_valid);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid act=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready act=%b exp=1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_s1_clear act=%b exp=0", out_valid); end
    in_valid = 1'b1; mant_pl = 68'h1; scale_in = 40'd5; in_pre = 2'b00;
    @(posedge clk);
    @(negedge clk);
    mant_pl = 68'h1 << 55; scale_in = 40'd100; in_pre = 2'b10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || mant_norm !== 68'h10000) begin
      failures++; $display("FAIL refill act=%b/%h exp=1/10000", out_valid, mant_norm);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid act=%b exp=0", out_valid); end
    checks++;
    if ({mant_norm, scale_out, lane_zero, pre_out} !== 114'd0) begin
      failures++; $display("FAIL arst_outputs act=%h exp=0", {mant_norm, scale_out, lane_zero, pre_out});
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_lost act=%b exp=0", out_valid); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mant_pl = '0; scale_in = '0; in_pre = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_back_pressure();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
